// File: rtl/chart_sequencer.sv
// Chart sequencer: walks the song chart ROM one entry per sixteenth pulse,
// with lead-in, pause, end-of-chart detection and restart.
module chart_sequencer #(
    parameter int CHART_DEPTH = 256,
    parameter int ADDR_W      = 8,
    parameter int LEAD_IN     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              pause_i,
    input  logic              sixteenth_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    output logic [3:0]        arrows_o,
    output logic [3:0]        timing_o,
    output logic              playing_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] step_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_FETCH, S_WAIT, S_PLAY, S_PAUSED, S_DONE
    } state_t;

    localparam logic [7:0]        END_CODE  = 8'h01;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHART_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [7:0]        LEAD_LOAD = 8'(LEAD_IN);

    state_t            r_state;
    state_t            r_saved;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_step;
    logic [7:0]        r_pending;
    logic [7:0]        r_lead;
    logic              r_tick;
    logic [1:0]        r_pf;
    logic [3:0]        r_arrows;
    logic [3:0]        r_timing;
    logic              r_playing;
    logic              r_done;

    logic              w_tick;
    logic              w_last;
    logic [7:0]        w_leadData;

    // A terminal lead tick landing on the capture cycle uses the ROM word directly.
    assign w_tick     = sixteenth_i | r_tick;
    assign w_last     = (r_addr == LAST_ADDR);
    assign w_leadData = (r_pf == 2'd1) ? rom_data_i : r_pending;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_saved   <= S_LEAD;
            r_addr    <= '0;
            r_step    <= '0;
            r_pending <= 8'h00;
            r_lead    <= 8'h00;
            r_tick    <= 1'b0;
            r_pf      <= 2'd0;
            r_arrows  <= 4'h0;
            r_timing  <= 4'h0;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_state   <= S_LEAD;
                        r_lead    <= LEAD_LOAD;
                        r_addr    <= '0;
                        r_step    <= '0;
                        r_pending <= 8'h00;
                        r_tick    <= 1'b0;
                        r_pf      <= 2'd2;
                        r_arrows  <= 4'h0;
                        r_timing  <= 4'h0;
                        r_playing <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                S_LEAD: begin
                    if (pause_i) begin
                        r_state   <= S_PAUSED;
                        r_saved   <= S_LEAD;
                        r_arrows  <= 4'h0;
                        r_timing  <= 4'h0;
                        r_playing <= 1'b0;
                    end else begin
                        if (r_pf == 2'd2) begin
                            r_pf <= 2'd1;
                        end else if (r_pf == 2'd1) begin
                            r_pending <= rom_data_i;
                            r_pf      <= 2'd0;
                        end
                        if (sixteenth_i) begin
                            if (r_lead <= 8'd1) begin
                                r_lead   <= 8'h00;
                                r_pf     <= 2'd0;
                                r_arrows <= w_leadData[7:4];
                                r_timing <= w_leadData[3:0];
                                r_step   <= r_step + ADDR_ONE;
                                if (w_last) begin
                                    r_pending <= END_CODE;
                                    r_state   <= S_PLAY;
                                end else begin
                                    r_addr  <= r_addr + ADDR_ONE;
                                    r_state <= S_FETCH;
                                end
                            end else begin
                                r_lead <= r_lead - 8'd1;
                            end
                        end
                    end
                end
                S_FETCH: begin
                    r_tick  <= r_tick | sixteenth_i;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_tick    <= r_tick | sixteenth_i;
                    r_pending <= rom_data_i;
                    r_state   <= S_PLAY;
                end
                S_PLAY: begin
                    if (pause_i) begin
                        r_state   <= S_PAUSED;
                        r_saved   <= S_PLAY;
                        r_arrows  <= 4'h0;
                        r_timing  <= 4'h0;
                        r_playing <= 1'b0;
                    end else if (w_tick) begin
                        // A fresh pulse coinciding with a latched one stays stored.
                        r_tick <= r_tick & sixteenth_i;
                        if (r_pending == END_CODE) begin
                            r_arrows  <= 4'h0;
                            r_timing  <= 4'h0;
                            r_state   <= S_DONE;
                            r_playing <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_arrows <= r_pending[7:4];
                            r_timing <= r_pending[3:0];
                            r_step   <= r_step + ADDR_ONE;
                            if (w_last) begin
                                r_pending <= END_CODE;
                            end else begin
                                r_addr  <= r_addr + ADDR_ONE;
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end
                S_PAUSED: begin
                    if (!pause_i) begin
                        r_state   <= r_saved;
                        r_playing <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr_o = r_addr;
    assign arrows_o   = r_arrows;
    assign timing_o   = r_timing;
    assign playing_o  = r_playing;
    assign done_o     = r_done;
    assign step_o     = r_step;

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: instance A (LEAD_IN=2, full depth) and
// instance B (LEAD_IN=1, CHART_DEPTH=4), each with its own synchronous ROM model.
module tb_chart_sequencer;

    logic       clock;
    logic       rstN;
    logic       startA, pauseA, sixA;
    logic       startB, pauseB, sixB;
    logic [7:0] romAddrA, romDataA, stepA;
    logic [7:0] romAddrB, romDataB, stepB;
    logic [3:0] arrowsA, timingA, arrowsB, timingB;
    logic       playingA, doneA, playingB, doneB;
    logic [7:0] romA [0:255];
    logic [7:0] romB [0:3];
    logic [7:0] entryV;
    int         testCount;
    int         failCount;
    int         prevStep;

    chart_sequencer #(.CHART_DEPTH(256), .ADDR_W(8), .LEAD_IN(2)) dutA (
        .clk_i(clock), .rst_ni(rstN), .start_i(startA), .pause_i(pauseA),
        .sixteenth_i(sixA), .rom_addr_o(romAddrA), .rom_data_i(romDataA),
        .arrows_o(arrowsA), .timing_o(timingA), .playing_o(playingA),
        .done_o(doneA), .step_o(stepA)
    );

    chart_sequencer #(.CHART_DEPTH(4), .ADDR_W(8), .LEAD_IN(1)) dutB (
        .clk_i(clock), .rst_ni(rstN), .start_i(startB), .pause_i(pauseB),
        .sixteenth_i(sixB), .rom_addr_o(romAddrB), .rom_data_i(romDataB),
        .arrows_o(arrowsB), .timing_o(timingB), .playing_o(playingB),
        .done_o(doneB), .step_o(stepB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM word appears one cycle after its address.
    always @(posedge clock) begin
        romDataA <= romA[romAddrA];
        romDataB <= romB[romAddrB[1:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit onB, input bit doStart, input bit doTick);
        @(negedge clock);
        if (onB) begin
            startB = doStart;
            sixB   = doTick;
        end else begin
            startA = doStart;
            sixA   = doTick;
        end
        @(negedge clock);
        startA = 1'b0;
        sixA   = 1'b0;
        startB = 1'b0;
        sixB   = 1'b0;
    endtask

    task automatic tickSettle(input bit onB);
        repeat (6) @(negedge clock);
        applyStimulus(onB, 1'b0, 1'b1);
        repeat (3) @(negedge clock);
    endtask

    task automatic doReset();
        @(negedge clock);
        rstN = 1'b0;
        @(negedge clock);
        rstN = 1'b1;
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rstN   = 1'b0;
        startA = 1'b0; pauseA = 1'b0; sixA = 1'b0;
        startB = 1'b0; pauseB = 1'b0; sixB = 1'b0;
        for (int i = 0; i < 256; i++) romA[i] = 8'h01;
        for (int i = 0; i < 4; i++) romB[i] = 8'h01;

        repeat (3) @(negedge clock);
        checkOutput("rst_addr",    32'(romAddrA), 32'h0);
        checkOutput("rst_arrows",  32'(arrowsA),  32'h0);
        checkOutput("rst_timing",  32'(timingA),  32'h0);
        checkOutput("rst_playing", 32'(playingA), 32'h0);
        checkOutput("rst_done",    32'(doneA),    32'h0);
        checkOutput("rst_step",    32'(stepA),    32'h0);
        @(negedge clock);
        rstN = 1'b1;

        // Two-entry chart with lead-in of two ticks.
        romA[0] = 8'h84;
        romA[1] = 8'h01;
        applyStimulus(1'b0, 1'b1, 1'b0);
        tickSettle(1'b0);
        checkOutput("lead_arrows",  32'(arrowsA),  32'h0);
        checkOutput("lead_step",    32'(stepA),    32'h0);
        checkOutput("lead_playing", 32'(playingA), 32'h1);
        tickSettle(1'b0);
        checkOutput("e0_arrows", 32'(arrowsA), 32'h8);
        checkOutput("e0_timing", 32'(timingA), 32'h4);
        checkOutput("e0_step",   32'(stepA),   32'h1);
        tickSettle(1'b0);
        checkOutput("end_arrows",  32'(arrowsA),  32'h0);
        checkOutput("end_timing",  32'(timingA),  32'h0);
        checkOutput("end_done",    32'(doneA),    32'h1);
        checkOutput("end_playing", 32'(playingA), 32'h0);

        // Restart from DONE, then assert reset while playing.
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("restart_done", 32'(doneA), 32'h0);
        checkOutput("restart_step", 32'(stepA), 32'h0);
        tickSettle(1'b0);
        tickSettle(1'b0);
        checkOutput("pre_rst_arrows", 32'(arrowsA), 32'h8);
        @(negedge clock);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midrst_arrows",  32'(arrowsA),  32'h0);
        checkOutput("midrst_timing",  32'(timingA),  32'h0);
        checkOutput("midrst_step",    32'(stepA),    32'h0);
        checkOutput("midrst_playing", 32'(playingA), 32'h0);
        checkOutput("midrst_addr",    32'(romAddrA), 32'h0);
        @(negedge clock);
        rstN = 1'b1;
        tickSettle(1'b0);
        checkOutput("idle_tick_step",    32'(stepA),    32'h0);
        checkOutput("idle_tick_playing", 32'(playingA), 32'h0);

        // Pause mid-chart after five entries.
        for (int i = 0; i < 10; i++) romA[i] = {4'(i + 1), 4'(15 - i)};
        romA[10] = 8'h01;
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (6) tickSettle(1'b0);
        checkOutput("prepause_step",   32'(stepA),   32'h5);
        checkOutput("prepause_arrows", 32'(arrowsA), 32'h5);
        checkOutput("prepause_timing", 32'(timingA), 32'hB);
        @(negedge clock);
        pauseA = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("pause_arrows",  32'(arrowsA),  32'h0);
        checkOutput("pause_timing",  32'(timingA),  32'h0);
        checkOutput("pause_playing", 32'(playingA), 32'h0);
        repeat (3) tickSettle(1'b0);
        checkOutput("paused_step",   32'(stepA),   32'h5);
        checkOutput("paused_arrows", 32'(arrowsA), 32'h0);
        @(negedge clock);
        pauseA = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("resume_arrows",  32'(arrowsA),  32'h0);
        checkOutput("resume_playing", 32'(playingA), 32'h1);
        tickSettle(1'b0);
        checkOutput("resume_e5_arrows", 32'(arrowsA), 32'h6);
        checkOutput("resume_e5_timing", 32'(timingA), 32'hA);
        checkOutput("resume_e5_step",   32'(stepA),   32'h6);

        // Ticks every two cycles, so some arrive during FETCH/WAIT.
        doReset();
        for (int i = 0; i < 8; i++) romA[i] = {4'(i + 1), 4'(15 - i)};
        romA[8] = 8'h01;
        applyStimulus(1'b0, 1'b1, 1'b0);
        prevStep = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clock);
            if (int'(stepA) != prevStep) begin
                entryV = romA[prevStep];
                checkOutput("fast_step",   32'(stepA),   32'(prevStep + 1));
                checkOutput("fast_arrows", 32'(arrowsA), 32'(entryV[7:4]));
                checkOutput("fast_timing", 32'(timingA), 32'(entryV[3:0]));
                prevStep = int'(stepA);
            end
            sixA = (c % 2 == 0);
        end
        sixA = 1'b0;
        @(negedge clock);
        checkOutput("fast_final_step", 32'(stepA),   32'h8);
        checkOutput("fast_final_done", 32'(doneA),   32'h1);
        checkOutput("fast_final_arr",  32'(arrowsA), 32'h0);

        // Rest entry, then a real entry, then END; LEAD_IN=1.
        romB[0] = 8'h00;
        romB[1] = 8'h2F;
        romB[2] = 8'h01;
        romB[3] = 8'h01;
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clock);
        checkOutput("b_addr0",   32'(romAddrB), 32'h0);
        checkOutput("b_playing", 32'(playingB), 32'h1);
        tickSettle(1'b1);
        checkOutput("b_rest_arrows", 32'(arrowsB),  32'h0);
        checkOutput("b_rest_timing", 32'(timingB),  32'h0);
        checkOutput("b_rest_step",   32'(stepB),    32'h1);
        checkOutput("b_addr1",       32'(romAddrB), 32'h1);
        tickSettle(1'b1);
        checkOutput("b_e1_arrows", 32'(arrowsB),  32'h2);
        checkOutput("b_e1_timing", 32'(timingB),  32'hF);
        checkOutput("b_addr2",     32'(romAddrB), 32'h2);
        tickSettle(1'b1);
        checkOutput("b_end_done",   32'(doneB),   32'h1);
        checkOutput("b_end_arrows", 32'(arrowsB), 32'h0);

        // Chart fills the whole ROM with no END entry.
        romB[0] = 8'h81;
        romB[1] = 8'h42;
        romB[2] = 8'h24;
        romB[3] = 8'h18;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("depth_restart_done", 32'(doneB), 32'h0);
        checkOutput("depth_restart_step", 32'(stepB), 32'h0);
        for (int j = 1; j <= 4; j++) begin
            tickSettle(1'b1);
            entryV = romB[j - 1];
            checkOutput("depth_step",   32'(stepB),    32'(j));
            checkOutput("depth_arrows", 32'(arrowsB),  32'(entryV[7:4]));
            checkOutput("depth_addr",   32'(romAddrB), (j < 3) ? 32'(j) : 32'h3);
        end
        tickSettle(1'b1);
        checkOutput("depth_done",   32'(doneB),    32'h1);
        checkOutput("depth_addr_x", 32'(romAddrB), 32'h3);
        checkOutput("depth_arr_x",  32'(arrowsB),  32'h0);

        // Start and tick together in DONE: the tick must not eat the lead-in.
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        checkOutput("simul_step",    32'(stepB),    32'h0);
        checkOutput("simul_done",    32'(doneB),    32'h0);
        checkOutput("simul_playing", 32'(playingB), 32'h1);
        checkOutput("simul_arrows",  32'(arrowsB),  32'h0);
        tickSettle(1'b1);
        checkOutput("simul_e0_step",   32'(stepB),   32'h1);
        checkOutput("simul_e0_arrows", 32'(arrowsB), 32'h8);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
